// File: rtl/rle_decode_if.sv
// Single-port dpsram bus between the RLE decoder (master) and the memory (slave).
interface rle_decode_if #(
    parameter int ADDR_W = 16
);
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;
    logic              port_A_we;

    modport master (
        output port_A_clk,
        output port_A_addr,
        output port_A_data_in,
        output port_A_we,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_addr,
        input  port_A_data_in,
        input  port_A_we,
        output port_A_data_out
    );
endinterface

// File: rtl/rle_decode.sv
// Expands a packed {byte,count} RLE stream from the dpsram back into plaintext words.
module rle_decode #(
    parameter int ADDR_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [31:0]  rle_addr,
    input  logic [31:0]  rle_size,
    input  logic [31:0]  message_addr,
    output logic [31:0]  message_size,
    output logic         done,
    rle_decode_if.master port_a
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        EXPAND,
        WRITE,
        FLUSH
    } state_t;

    state_t            state;
    state_t            ret_state;
    logic [ADDR_W-1:0] read_addr;
    logic [ADDR_W-1:0] write_addr;
    logic [31:0]       words_left;
    logic [31:0]       entry;
    logic              half;
    logic [7:0]        run_cnt;
    logic [1:0]        byte_idx;
    logic [31:0]       pack_buf;
    logic [31:0]       data_in;
    logic              we;

    logic [7:0]        cur_byte;
    logic              run_zero;
    logic              entry_end;
    logic              buf_full;
    state_t            after_entry;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W]};

    assign port_a.port_A_clk     = clk;
    assign port_a.port_A_addr    = we ? write_addr : read_addr;
    assign port_a.port_A_data_in = data_in;
    assign port_a.port_A_we      = we;

    // A zero run count marks a padding entry: it ends immediately without emitting a byte.
    always_comb begin
        cur_byte    = half ? entry[31:24] : entry[15:8];
        run_zero    = (run_cnt == 8'd0);
        entry_end   = run_zero || (run_cnt == 8'd1);
        buf_full    = !run_zero && (byte_idx == 2'd3);
        after_entry = EXPAND;
        if (entry_end && half) begin
            after_entry = (words_left != 32'd0) ? READ : FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ret_state    <= IDLE;
            done         <= 1'b0;
            we           <= 1'b0;
            message_size <= 32'd0;
            data_in      <= 32'd0;
            read_addr    <= '0;
            write_addr   <= '0;
            words_left   <= 32'd0;
            entry        <= 32'd0;
            half         <= 1'b0;
            run_cnt      <= 8'd0;
            byte_idx     <= 2'd0;
            pack_buf     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        read_addr    <= rle_addr[ADDR_W-1:0];
                        write_addr   <= message_addr[ADDR_W-1:0];
                        words_left   <= {2'b00, rle_size[31:2]} + {31'd0, |rle_size[1:0]};
                        message_size <= 32'd0;
                        byte_idx     <= 2'd0;
                        pack_buf     <= 32'd0;
                        half         <= 1'b0;
                        run_cnt      <= 8'd0;
                        if (rle_size == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            done  <= 1'b0;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    read_addr  <= read_addr + ADDR_W'(4);
                    words_left <= words_left - 32'd1;
                    state      <= CAPT;
                end
                CAPT: begin
                    entry   <= port_a.port_A_data_out;
                    run_cnt <= port_a.port_A_data_out[7:0];
                    half    <= 1'b0;
                    state   <= EXPAND;
                end
                EXPAND: begin
                    if (!run_zero) begin
                        run_cnt      <= run_cnt - 8'd1;
                        message_size <= message_size + 32'd1;
                        byte_idx     <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            data_in  <= {cur_byte, pack_buf[23:0]};
                            pack_buf <= 32'd0;
                            we       <= 1'b1;
                        end else begin
                            pack_buf[{byte_idx, 3'b000} +: 8] <= cur_byte;
                        end
                    end
                    if (entry_end && !half) begin
                        half    <= 1'b1;
                        run_cnt <= entry[23:16];
                    end
                    if (buf_full) begin
                        state     <= WRITE;
                        ret_state <= after_entry;
                    end else begin
                        state <= after_entry;
                    end
                end
                WRITE: begin
                    we         <= 1'b0;
                    write_addr <= write_addr + ADDR_W'(4);
                    state      <= ret_state;
                end
                // A partial word goes out through WRITE and comes back here with byte_idx cleared.
                FLUSH: begin
                    if (byte_idx != 2'd0) begin
                        data_in   <= pack_buf;
                        pack_buf  <= 32'd0;
                        byte_idx  <= 2'd0;
                        we        <= 1'b1;
                        state     <= WRITE;
                        ret_state <= FLUSH;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_decode.sv
// Directed bench for rle_decode: a word-addressed memory model supplies the RLE stream and logs writes.
module tb_rle_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic        done;

    int assert_count = 0;
    int fail_count   = 0;
    int base;
    int base2;

    logic [31:0] mem [0:16383];
    logic [31:0] wr_data [0:255];
    logic [15:0] wr_addr_log [0:255];
    int          wr_count = 0;

    always #5 clk = ~clk;

    rle_decode_if #(.ADDR_W(16)) bus();

    rle_decode #(.ADDR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rle_addr     (rle_addr),
        .rle_size     (rle_size),
        .message_addr (message_addr),
        .message_size (message_size),
        .done         (done),
        .port_a       (bus)
    );

    // Synchronous-read memory; writes are only logged since the decoder never reads them back.
    always @(posedge clk) begin
        bus.port_A_data_out <= mem[bus.port_A_addr[15:2]];
        if (bus.port_A_we) begin
            wr_data[wr_count[7:0]]     <= bus.port_A_data_in;
            wr_addr_log[wr_count[7:0]] <= bus.port_A_addr;
            wr_count                   <= wr_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
        @(negedge clk);
        base         = wr_count;
        rle_addr     = ra;
        rle_size     = rs;
        message_addr = ma;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) begin
            @(negedge clk);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        rle_addr     = 32'd0;
        rle_size     = 32'd0;
        message_addr = 32'd0;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 32'd0;
        end
        repeat (3) @(negedge clk);

        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_we", {31'd0, bus.port_A_we}, 32'd0);
        checkOutput("reset_msize", message_size, 32'd0);
        checkOutput("reset_data_in", bus.port_A_data_in, 32'd0);
        checkOutput("reset_addr", {16'd0, bus.port_A_addr}, 32'd0);
        reset = 1'b0;

        $display("[TB] single entry with padding half");
        mem[32'h40] = 32'h0000_4103;
        applyStimulus(32'h100, 32'd4, 32'h1000);
        waitDone(200);
        checkOutput("t2_done", {31'd0, done}, 32'd1);
        checkOutput("t2_msize", message_size, 32'd3);
        checkOutput("t2_nwrites", wr_count - base, 32'd1);
        checkOutput("t2_data", wr_data[base[7:0]], 32'h0041_4141);
        checkOutput("t2_addr", {16'd0, wr_addr_log[base[7:0]]}, 32'h1000);

        $display("[TB] two entries spanning a word boundary");
        mem[32'h40] = 32'h4202_4103;
        applyStimulus(32'h100, 32'd4, 32'h1000);
        checkOutput("t3_done_drop", {31'd0, done}, 32'd0);
        waitDone(200);
        checkOutput("t3_done", {31'd0, done}, 32'd1);
        checkOutput("t3_msize", message_size, 32'd5);
        checkOutput("t3_nwrites", wr_count - base, 32'd2);
        checkOutput("t3_data0", wr_data[base[7:0]], 32'h4241_4141);
        checkOutput("t3_data1", wr_data[8'(base + 1)], 32'h0000_0042);
        checkOutput("t3_addr1", {16'd0, wr_addr_log[8'(base + 1)]}, 32'h1004);

        $display("[TB] rle_size not a multiple of four reads whole word");
        applyStimulus(32'h100, 32'd2, 32'h1800);
        waitDone(200);
        checkOutput("odd_msize", message_size, 32'd5);
        checkOutput("odd_nwrites", wr_count - base, 32'd2);
        checkOutput("odd_data1", wr_data[8'(base + 1)], 32'h0000_0042);

        $display("[TB] maximum run of 255");
        mem[32'h40] = 32'h0000_7FFF;
        applyStimulus(32'h100, 32'd4, 32'h2000);
        waitDone(2000);
        checkOutput("t4_done", {31'd0, done}, 32'd1);
        checkOutput("t4_msize", message_size, 32'd255);
        checkOutput("t4_nwrites", wr_count - base, 32'd64);
        for (int i = 0; i < 63; i++) begin
            checkOutput($sformatf("t4_data%0d", i), wr_data[8'(base + i)], 32'h7F7F_7F7F);
        end
        checkOutput("t4_last", wr_data[8'(base + 63)], 32'h007F_7F7F);
        checkOutput("t4_last_addr", {16'd0, wr_addr_log[8'(base + 63)]}, 32'h20FC);

        $display("[TB] reset in the middle of a run");
        applyStimulus(32'h100, 32'd4, 32'h3000);
        repeat (40) @(negedge clk);
        checkOutput("t1_busy", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t1_we", {31'd0, bus.port_A_we}, 32'd0);
        checkOutput("t1_done", {31'd0, done}, 32'd0);
        checkOutput("t1_msize", message_size, 32'd0);
        checkOutput("t1_addr", {16'd0, bus.port_A_addr}, 32'd0);
        base2 = wr_count;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t1_no_writes", wr_count - base2, 32'd0);
        checkOutput("t1_idle_done", {31'd0, done}, 32'd0);

        $display("[TB] empty stream");
        applyStimulus(32'h100, 32'd0, 32'h3000);
        checkOutput("t5_done", {31'd0, done}, 32'd1);
        checkOutput("t5_msize", message_size, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t5_nwrites", wr_count - base, 32'd0);

        $display("[TB] round trip of AAAABBBCDD");
        mem[32'h80] = 32'h4203_4104;
        mem[32'h81] = 32'h4402_4301;
        mem[32'h82] = 32'h0000_0000;
        applyStimulus(32'h200, 32'd12, 32'h4000);
        waitDone(500);
        checkOutput("t6_done", {31'd0, done}, 32'd1);
        checkOutput("t6_msize", message_size, 32'd10);
        checkOutput("t6_nwrites", wr_count - base, 32'd3);
        checkOutput("t6_data0", wr_data[8'(base)], 32'h4141_4141);
        checkOutput("t6_data1", wr_data[8'(base + 1)], 32'h4342_4242);
        checkOutput("t6_data2", wr_data[8'(base + 2)], 32'h0000_4444);
        checkOutput("t6_addr2", {16'd0, wr_addr_log[8'(base + 2)]}, 32'h4008);
        repeat (3) @(negedge clk);
        checkOutput("t6_done_hold", {31'd0, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
